// File: rtl/fpu_pipe_pkg.sv
// Shared types and constants for the four-stage FP add/sub pipeline controller.
package fpu_pipe_pkg;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned N_STG = 4;
  localparam int unsigned CNT_W = 3;

  localparam int unsigned STG_A = 0;
  localparam int unsigned STG_C = 1;
  localparam int unsigned STG_N = 2;
  localparam int unsigned STG_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fpipe_hazard_cmp.sv
// Per-stage tag comparator: flags which issuing source registers match a valid stage destination.
module fpipe_hazard_cmp #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] fs,
  input  logic [TAG_W-1:0] ft,
  input  logic             use_fs,
  input  logic             use_ft,
  output logic             match_fs,
  output logic             match_ft
);

  always_comb begin
    match_fs = valid & use_fs & (tag == fs);
    match_ft = valid & use_ft & (tag == ft);
  end

endmodule

// File: rtl/fadd_pipe_ctrl.sv
// Sequencing controller for the A/C/N/W FP add/sub pipeline: enables, hazards, stall/flush/drain.
module fadd_pipe_ctrl #(
  parameter int unsigned TAG_W = fpu_pipe_pkg::TAG_W
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             issue,
  input  logic [TAG_W-1:0] issue_fd,
  input  logic [TAG_W-1:0] issue_fs,
  input  logic [TAG_W-1:0] issue_ft,
  input  logic             use_fs,
  input  logic             use_ft,
  input  logic             stall_ext,
  input  logic             flush,
  input  logic             sync_req,
  output logic             stall_id,
  output logic             e_a,
  output logic             e_ac,
  output logic             e_cn,
  output logic             e_nw,
  output logic             fwd_fs_w,
  output logic             fwd_ft_w,
  output logic             wb_we,
  output logic [TAG_W-1:0] wb_fd,
  output logic             sync_ack,
  output logic             busy
);

  import fpu_pipe_pkg::*;

  logic [N_STG-1:0] v;
  logic [TAG_W-1:0] fd [N_STG];
  logic [N_STG-1:0] m_fs;
  logic [N_STG-1:0] m_ft;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  state_t           state;

  logic dep;
  logic accept;
  logic retire;
  logic kill;

  for (genvar i = 0; i < N_STG; i++) begin : g_cmp
    fpipe_hazard_cmp #(.TAG_W(TAG_W)) u_cmp (
      .valid    (v[i]),
      .tag      (fd[i]),
      .fs       (issue_fs),
      .ft       (issue_ft),
      .use_fs   (use_fs),
      .use_ft   (use_ft),
      .match_fs (m_fs[i]),
      .match_ft (m_ft[i])
    );
  end

  always_comb begin
    // W is excluded from the hazard: its result is bypassed instead of stalled on.
    dep      = |(m_fs[STG_N:STG_A] | m_ft[STG_N:STG_A]);
    fwd_fs_w = m_fs[STG_W];
    fwd_ft_w = m_ft[STG_W];

    sync_ack = (cnt == '0) && ((state == DRAIN) || ((state == IDLE) && sync_req));
    stall_id = (issue & (stall_ext | dep | (state == DRAIN))) | (sync_req & ~sync_ack);
    accept   = issue & ~stall_id & ~flush;

    e_ac = ~stall_ext;
    e_cn = ~stall_ext;
    e_nw = ~stall_ext;
    e_a  = ~stall_ext & accept;

    retire = v[STG_W] & ~stall_ext;
    wb_we  = retire;
    wb_fd  = fd[STG_W];

    // A flushed op in A never reaches W, so it leaves the occupancy count here.
    kill     = flush & v[STG_A];
    cnt_next = cnt + {{(CNT_W-1){1'b0}}, accept}
                   - {{(CNT_W-1){1'b0}}, retire}
                   - {{(CNT_W-1){1'b0}}, kill};
    busy     = (cnt != '0);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      v <= '0;
      for (int unsigned i = 0; i < N_STG; i++) fd[i] <= '0;
    end else if (!stall_ext) begin
      v[STG_A] <= accept;
      v[STG_C] <= v[STG_A] & ~flush;
      v[STG_N] <= v[STG_C];
      v[STG_W] <= v[STG_N];
      if (accept) fd[STG_A] <= issue_fd;
      fd[STG_C] <= fd[STG_A];
      fd[STG_N] <= fd[STG_C];
      fd[STG_W] <= fd[STG_N];
    end else if (flush) begin
      v[STG_A] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt_next;
      case (state)
        IDLE: begin
          if (sync_req && busy) state <= DRAIN;
          else if (accept)      state <= RUN;
        end
        RUN: begin
          if (sync_req && busy)           state <= DRAIN;
          else if ((cnt == '0) && !accept) state <= IDLE;
        end
        DRAIN: begin
          if (cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_pipe_ctrl.sv
// Directed bench for fadd_pipe_ctrl with hand-computed cycle expectations.
module tb_fadd_pipe_ctrl;

  localparam int unsigned TW = 5;

  logic          clock = 1'b0;
  logic          clrn;
  logic          issue;
  logic [TW-1:0] issue_fd, issue_fs, issue_ft;
  logic          use_fs, use_ft;
  logic          stall_ext, flush, sync_req;
  logic          stall_id, e_a, e_ac, e_cn, e_nw;
  logic          fwd_fs_w, fwd_ft_w, wb_we, sync_ack, busy;
  logic [TW-1:0] wb_fd;

  int pass_cnt = 0;
  int total_cnt = 0;

  fadd_pipe_ctrl #(.TAG_W(TW)) dut (
    .clock(clock), .clrn(clrn), .issue(issue), .issue_fd(issue_fd),
    .issue_fs(issue_fs), .issue_ft(issue_ft), .use_fs(use_fs), .use_ft(use_ft),
    .stall_ext(stall_ext), .flush(flush), .sync_req(sync_req),
    .stall_id(stall_id), .e_a(e_a), .e_ac(e_ac), .e_cn(e_cn), .e_nw(e_nw),
    .fwd_fs_w(fwd_fs_w), .fwd_ft_w(fwd_ft_w), .wb_we(wb_we), .wb_fd(wb_fd),
    .sync_ack(sync_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iss, input logic [TW-1:0] d, input logic [TW-1:0] s,
                       input logic [TW-1:0] t, input logic ufs, input logic uft);
    issue = iss; issue_fd = d; issue_fs = s; issue_ft = t; use_fs = ufs; use_ft = uft;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    clrn = 1'b0; drive(0, 0, 0, 0, 0, 0);
    stall_ext = 0; flush = 0; sync_req = 0;
    #2;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL reset_wb_we: got %b want 0", wb_we); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL reset_stall_id: got %b want 0", stall_id); else pass_cnt++;
    total_cnt++; if (sync_ack !== 1'b0) $display("FAIL reset_sync_ack: got %b want 0", sync_ack); else pass_cnt++;
    @(posedge clock); @(posedge clock); #1;
    clrn = 1'b1;
    step();
  endtask

  task automatic test_single();
    drive(1, 3, 0, 0, 0, 0); #1;
    total_cnt++; if (e_a !== 1'b1) $display("FAIL single_e_a: got %b want 1", e_a); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL single_stall_id: got %b want 0", stall_id); else pass_cnt++;
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b0) $display("FAIL single_early_wb c%0d: got %b want 0", c, wb_we); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy c%0d: got %b want 1", c, busy); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (wb_we !== 1'b1) $display("FAIL single_wb_we c4: got %b want 1", wb_we); else pass_cnt++;
    total_cnt++; if (wb_fd !== 5'd3) $display("FAIL single_wb_fd c4: got %0d want 3", wb_fd); else pass_cnt++;
    step(); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy c5: got %b want 0", busy); else pass_cnt++;
    idle_cycles(2);
  endtask

  task automatic test_raw();
    drive(1, 5, 0, 0, 0, 0); #1;
    total_cnt++; if (e_a !== 1'b1) $display("FAIL raw_prod_e_a: got %b want 1", e_a); else pass_cnt++;
    step();
    drive(1, 6, 5, 0, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      total_cnt++; if (stall_id !== 1'b1) $display("FAIL raw_stall_id c%0d: got %b want 1", c, stall_id); else pass_cnt++;
      total_cnt++; if (e_a !== 1'b0) $display("FAIL raw_e_a c%0d: got %b want 0", c, e_a); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL raw_stall_id c4: got %b want 0", stall_id); else pass_cnt++;
    total_cnt++; if (fwd_fs_w !== 1'b1) $display("FAIL raw_fwd_fs_w c4: got %b want 1", fwd_fs_w); else pass_cnt++;
    total_cnt++; if (fwd_ft_w !== 1'b0) $display("FAIL raw_fwd_ft_w c4: got %b want 0", fwd_ft_w); else pass_cnt++;
    total_cnt++; if (wb_fd !== 5'd5 || wb_we !== 1'b1) $display("FAIL raw_prod_wb c4: got we=%b fd=%0d want we=1 fd=5", wb_we, wb_fd); else pass_cnt++;
    total_cnt++; if (e_a !== 1'b1) $display("FAIL raw_cons_e_a c4: got %b want 1", e_a); else pass_cnt++;
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 5; c <= 7; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b0) $display("FAIL raw_cons_early c%0d: got %b want 0", c, wb_we); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (wb_we !== 1'b1 || wb_fd !== 5'd6) $display("FAIL raw_cons_wb c8: got we=%b fd=%0d want we=1 fd=6", wb_we, wb_fd); else pass_cnt++;
    step(); #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL raw_busy c9: got %b want 0", busy); else pass_cnt++;
    idle_cycles(2);
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'(c + 1), 0, 0, 0, 0);
      step();
    end
    stall_ext = 1; drive(1, 7, 0, 0, 0, 0); #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL stall_stall_id c3: got %b want 1", stall_id); else pass_cnt++;
    total_cnt++; if ({e_a, e_ac, e_cn, e_nw} !== 4'b0000) $display("FAIL stall_enables c3: got %b want 0000", {e_a, e_ac, e_cn, e_nw}); else pass_cnt++;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL stall_wb_we c3: got %b want 0", wb_we); else pass_cnt++;
    step();
    drive(0, 0, 0, 0, 0, 0); #1;
    total_cnt++; if (e_ac !== 1'b0 || wb_we !== 1'b0) $display("FAIL stall_hold c4: got e_ac=%b we=%b want 0 0", e_ac, wb_we); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL stall_busy c4: got %b want 1", busy); else pass_cnt++;
    step();
    stall_ext = 0; #1;
    total_cnt++; if (e_ac !== 1'b1 || wb_we !== 1'b0) $display("FAIL stall_resume c5: got e_ac=%b we=%b want 1 0", e_ac, wb_we); else pass_cnt++;
    step();
    for (int c = 6; c <= 8; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b1 || wb_fd !== 5'(c - 5)) $display("FAIL stall_wb c%0d: got we=%b fd=%0d want we=1 fd=%0d", c, wb_we, wb_fd, c - 5); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL stall_busy c9: got %b want 0", busy); else pass_cnt++;
    idle_cycles(2);
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'(c + 1), 0, 0, 0, 0);
      step();
    end
    flush = 1; drive(1, 4, 0, 0, 0, 0); #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL flush_stall_id c3: got %b want 0", stall_id); else pass_cnt++;
    total_cnt++; if (e_a !== 1'b0) $display("FAIL flush_e_a c3: got %b want 0", e_a); else pass_cnt++;
    step();
    flush = 0; drive(0, 0, 0, 0, 0, 0);
    for (int c = 4; c <= 5; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b1 || wb_fd !== 5'(c - 3)) $display("FAIL flush_wb c%0d: got we=%b fd=%0d want we=1 fd=%0d", c, wb_we, wb_fd, c - 3); else pass_cnt++;
      step();
    end
    for (int c = 6; c <= 8; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b0) $display("FAIL flush_no_wb c%0d: got %b want 0", c, wb_we); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy c%0d: got %b want 0", c, busy); else pass_cnt++;
      step();
    end
    idle_cycles(1);
  endtask

  task automatic test_sync();
    int ack_cyc;
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'(c + 1), 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    sync_req = 1;
    ack_cyc = -1;
    for (int c = 3; c < 23; c++) begin
      #1;
      if (sync_ack === 1'b1) begin
        ack_cyc = c;
        break;
      end
      total_cnt++; if (stall_id !== 1'b1) $display("FAIL sync_stall_id c%0d: got %b want 1", c, stall_id); else pass_cnt++;
      step();
    end
    total_cnt++; if (ack_cyc != 7) $display("FAIL sync_ack_cycle: got %0d want 7 (-1 means timeout)", ack_cyc); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL sync_stall_at_ack: got %b want 0", stall_id); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sync_busy_at_ack: got %b want 0", busy); else pass_cnt++;
    step();
    sync_req = 0; #1;
    total_cnt++; if (sync_ack !== 1'b0) $display("FAIL sync_single_pulse: got %b want 0", sync_ack); else pass_cnt++;
    step(); step();
    sync_req = 1; #1;
    total_cnt++; if (sync_ack !== 1'b1) $display("FAIL sync_immediate_ack: got %b want 1", sync_ack); else pass_cnt++;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL sync_immediate_stall: got %b want 0", stall_id); else pass_cnt++;
    step();
    sync_req = 0;
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      drive(1, 5'(10 + c), 0, 0, 0, 0); #1;
      total_cnt++; if (stall_id !== 1'b0 || e_a !== 1'b1) $display("FAIL b2b_accept c%0d: got stall=%b e_a=%b want 0 1", c, stall_id, e_a); else pass_cnt++;
      if (c == 4) begin
        total_cnt++; if (wb_we !== 1'b1 || wb_fd !== 5'd10) $display("FAIL b2b_wb c4: got we=%b fd=%0d want we=1 fd=10", wb_we, wb_fd); else pass_cnt++;
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 5; c <= 8; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b1 || wb_fd !== 5'(c + 6)) $display("FAIL b2b_wb c%0d: got we=%b fd=%0d want we=1 fd=%0d", c, wb_we, wb_fd, c + 6); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy c%0d: got %b want 1", c, busy); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy c9: got %b want 0", busy); else pass_cnt++;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'(20 + c), 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0); #1;
    total_cnt++; if (wb_we !== 1'b1 || wb_fd !== 5'd20) $display("FAIL rstmid_pre_wb: got we=%b fd=%0d want we=1 fd=20", wb_we, wb_fd); else pass_cnt++;
    clrn = 1'b0; #1;
    total_cnt++; if (wb_we !== 1'b0) $display("FAIL rstmid_wb_we: got %b want 0", wb_we); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (wb_fd !== 5'd0) $display("FAIL rstmid_wb_fd: got %0d want 0", wb_fd); else pass_cnt++;
    total_cnt++; if ({stall_id, e_a, fwd_fs_w, fwd_ft_w, sync_ack} !== 5'b0) $display("FAIL rstmid_misc: got %b want 00000", {stall_id, e_a, fwd_fs_w, fwd_ft_w, sync_ack}); else pass_cnt++;
    step(); step();
    clrn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total_cnt++; if (wb_we !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_after c%0d: got we=%b busy=%b want 0 0", c, wb_we, busy); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_raw();
    test_stall();
    test_flush();
    test_sync();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
